// File: rtl/fetch_pkg.sv
// Shared fetch-side constants and helpers used by the aligner, its line
// extractor and, downstream, decode.
package fetch_pkg;

  localparam int INST_W = 32;

  // Canonical LoongArch NOP (andi r0, r0, 0), for decode-side bubble insertion.
  localparam logic [INST_W-1:0] LOONGARCH_NOP = 32'h0340_0000;

  // $clog2 that never returns 0, so single-entry parameters still give a
  // legal 1-bit index.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/fetch_line_extract.sv
// Combinational line aligner: shifts a cache line down so word[offset] lands
// in slot 0, and reports how many words remain to the end of the line.
module fetch_line_extract
  import fetch_pkg::*;
#(
  parameter  int LINE_WORDS = 4,
  localparam int OFF_W      = clog2_min1(LINE_WORDS),
  localparam int N_W        = $clog2(LINE_WORDS) + 1
) (
  input  logic [LINE_WORDS*INST_W-1:0] line_data,
  input  logic [OFF_W-1:0]             offset,
  output logic [LINE_WORDS*INST_W-1:0] words,
  output logic [N_W-1:0]               push_n
);

  // Upper slots fill with zeros; the queue only writes the first push_n.
  assign words  = line_data >> (offset * INST_W);
  assign push_n = N_W'(LINE_WORDS) - N_W'(offset);

endmodule

// File: rtl/fetch_align_queue.sv
// Fetch aligner and circular instruction queue between the I-cache read port
// and decode: one line in per cycle, up to FETCH_WIDTH instructions out.
module fetch_align_queue
  import fetch_pkg::*;
#(
  parameter  int LINE_WORDS  = 4,
  parameter  int FETCH_WIDTH = 2,
  parameter  int DEPTH       = 8,
  parameter  int PC_W        = 32,
  localparam int OFF_W       = clog2_min1(LINE_WORDS)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic                          line_valid,
  output logic                          line_ready,
  input  logic [LINE_WORDS*INST_W-1:0]  line_data,
  input  logic [OFF_W-1:0]              offset,
  input  logic [PC_W-1:0]               line_pc,
  output logic [FETCH_WIDTH-1:0]        out_valid,
  output logic [FETCH_WIDTH*INST_W-1:0] out_inst,
  output logic [FETCH_WIDTH*PC_W-1:0]   out_pc,
  input  logic                          out_ready
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int N_W   = $clog2(LINE_WORDS) + 1;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [LINE_WORDS*INST_W-1:0] words;
  logic [N_W-1:0]               push_n;
  logic [CNT_W-1:0]             pop_n;
  logic                         push;

  fetch_line_extract #(
    .LINE_WORDS (LINE_WORDS)
  ) u_extract (
    .line_data (line_data),
    .offset    (offset),
    .words     (words),
    .push_n    (push_n)
  );

  // Room for a whole line is required even when only part of it is wanted,
  // so line_ready depends on registered count alone.
  assign line_ready = (count <= CNT_W'(DEPTH - LINE_WORDS));
  assign push       = line_valid && line_ready && !flush;

  always_comb begin
    pop_n = '0;
    if (out_ready) begin
      pop_n = (count >= CNT_W'(FETCH_WIDTH)) ? CNT_W'(FETCH_WIDTH) : count;
    end
  end

  // NOTE: storage has no reset; validity is carried entirely by count, so
  // stale entries are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LINE_WORDS; j++) begin
      if (push && (N_W'(j) < push_n)) begin
        inst_mem[tail + PTR_W'(j)] <= words[j*INST_W +: INST_W];
        pc_mem[tail + PTR_W'(j)]   <= line_pc + PC_W'(4 * j);
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, which is what makes push and pop in the same
  // cycle see the old contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      if (push) begin
        tail <= tail + PTR_W'(push_n);
      end
      count <= count + (push ? CNT_W'(push_n) : '0) - pop_n;
    end
  end

  // NOTE: every output gets a default before the loop so the block stays
  // purely combinational with no inferred latch on invalid lanes.
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (CNT_W'(k) < count) begin
        out_valid[k]                = 1'b1;
        out_inst[k*INST_W +: INST_W] = inst_mem[head + PTR_W'(k)];
        out_pc[k*PC_W +: PC_W]       = pc_mem[head + PTR_W'(k)];
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Directed self-checking bench for fetch_align_queue at default parameters
// (LINE_WORDS 4, FETCH_WIDTH 2, DEPTH 8, PC_W 32).
module tb_fetch_align_queue;

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush;
  logic         line_valid;
  logic         line_ready;
  logic [127:0] line_data;
  logic [1:0]   offset;
  logic [31:0]  line_pc;
  logic [1:0]   out_valid;
  logic [63:0]  out_inst;
  logic [63:0]  out_pc;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_align_queue dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .offset     (offset),
    .line_pc    (line_pc),
    .out_valid  (out_valid),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_ready  (out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input logic [31:0] pc, input logic [1:0] off,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    line_valid = 1'b1;
    line_pc    = pc;
    offset     = off;
    line_data  = {w3, w2, w1, w0};
  endtask

  task automatic lanes(input string tag, input logic [1:0] v,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p0, input logic [31:0] p1);
    check({tag, "_valid"}, 64'(out_valid), 64'(v));
    check({tag, "_inst"},  out_inst, {i1, i0});
    check({tag, "_pc"},    out_pc,   {p1, p0});
  endtask

  initial begin
    rstn       = 1'b0;
    flush      = 1'b0;
    line_valid = 1'b0;
    line_data  = '0;
    offset     = '0;
    line_pc    = '0;
    out_ready  = 1'b0;
    #1;
    lanes("reset", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    check("reset_ready", 64'(line_ready), 64'd1);
    #2 rstn = 1'b1;

    // Basic line at offset 0, then drain.
    drive_line(32'h1c00_0000, 2'd0, 32'h11, 32'h22, 32'h33, 32'h44);
    step();
    line_valid = 1'b0;
    lanes("l0_a", 2'b11, 32'h11, 32'h22, 32'h1c00_0000, 32'h1c00_0004);
    out_ready = 1'b1;
    step();
    lanes("l0_b", 2'b11, 32'h33, 32'h44, 32'h1c00_0008, 32'h1c00_000c);
    step();
    lanes("l0_empty", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    lanes("empty_pop", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

    // Offset 3: single entry, lane 1 zeroed.
    out_ready = 1'b0;
    drive_line(32'h1c00_001c, 2'd3, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    step();
    line_valid = 1'b0;
    lanes("off3", 2'b01, 32'hA4, 32'h0, 32'h1c00_001c, 32'h0);
    out_ready = 1'b1;
    step();
    lanes("off3_drain", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

    // Fill to DEPTH with decode stalled (entries 5,6,7,0 then 1..4).
    out_ready = 1'b0;
    drive_line(32'h100, 2'd0, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
    step();
    check("fill4_ready", 64'(line_ready), 64'd1);
    drive_line(32'h200, 2'd0, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
    step();
    check("fill8_ready", 64'(line_ready), 64'd0);
    lanes("fill8", 2'b11, 32'hB0, 32'hB1, 32'h100, 32'h104);
    drive_line(32'h900, 2'd0, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
    step();
    lanes("held", 2'b11, 32'hB0, 32'hB1, 32'h100, 32'h104);
    out_ready = 1'b1;
    step();
    check("pop6_ready", 64'(line_ready), 64'd0);
    lanes("pop6", 2'b11, 32'hB2, 32'hB3, 32'h108, 32'h10c);
    step();
    line_valid = 1'b0;
    check("pop4_ready", 64'(line_ready), 64'd1);
    lanes("pop4", 2'b11, 32'hC0, 32'hC1, 32'h200, 32'h204);
    step();
    lanes("pop2", 2'b11, 32'hC2, 32'hC3, 32'h208, 32'h20c);
    step();
    lanes("pop0", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

    // Simultaneous push and pop at count 3, wrapping entry 7 -> 0.
    out_ready = 1'b0;
    drive_line(32'h300, 2'd1, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
    step();
    lanes("e3", 2'b11, 32'hE1, 32'hE2, 32'h300, 32'h304);
    drive_line(32'h400, 2'd2, 32'hF0, 32'hF1, 32'hF2, 32'hF3);
    out_ready = 1'b1;
    step();
    line_valid = 1'b0;
    lanes("pushpop", 2'b11, 32'hE3, 32'hF2, 32'h308, 32'h400);
    step();
    lanes("wrap_tail", 2'b01, 32'hF3, 32'h0, 32'h404, 32'h0);
    step();
    lanes("wrap_empty", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

    // Count 5 is the full boundary; then flush with push and pop requested.
    out_ready = 1'b0;
    drive_line(32'h600, 2'd0, 32'h60, 32'h61, 32'h62, 32'h63);
    step();
    drive_line(32'h70c, 2'd3, 32'h70, 32'h71, 32'h72, 32'h73);
    step();
    lanes("cnt5", 2'b11, 32'h60, 32'h61, 32'h600, 32'h604);
    drive_line(32'h800, 2'd0, 32'h80, 32'h81, 32'h82, 32'h83);
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    check("cnt5_ready_pop", 64'(line_ready), 64'd0);
    step();
    lanes("flush5", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    check("flush5_ready", 64'(line_ready), 64'd1);
    step();
    flush      = 1'b0;
    line_valid = 1'b0;
    lanes("flush_push", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

    // Async reset at count 6, then resume with a PC that wraps.
    out_ready = 1'b0;
    drive_line(32'ha00, 2'd0, 32'h90, 32'h91, 32'h92, 32'h93);
    step();
    drive_line(32'hb08, 2'd2, 32'h94, 32'h95, 32'h96, 32'h97);
    step();
    line_valid = 1'b0;
    lanes("cnt6", 2'b11, 32'h90, 32'h91, 32'ha00, 32'ha04);
    rstn = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_ready", 64'(line_ready), 64'd1);
    #1 rstn = 1'b1;
    drive_line(32'hffff_fffc, 2'd0, 32'hC5, 32'hC6, 32'hC7, 32'hC8);
    step();
    line_valid = 1'b0;
    lanes("resume_wrap", 2'b11, 32'hC5, 32'hC6, 32'hffff_fffc, 32'h0);
    out_ready = 1'b1;
    step();
    lanes("resume_b", 2'b11, 32'hC7, 32'hC8, 32'h4, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_align_queue.md
# fetch_align_queue

Parametrised instruction-fetch aligner and queue between the I-cache read port and decode. Each cycle it accepts one cache line plus a word offset, extracts every instruction from the offset to the end of the line, and enqueues them with their PCs. Decode then receives up to FETCH_WIDTH in-order instructions per cycle under a valid/ready handshake. A flush input discards everything on redirect.

## Interface
- LINE_WORDS, 4: 32-bit words per cache line; power of two, ≥2
- FETCH_WIDTH, 2: instructions offered to decode per cycle; power of two, ≤ LINE_WORDS
- DEPTH, 8: queue entries; power of two, ≥ LINE_WORDS
- PC_W, 32: PC width
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- flush  in  1  discard all entries; ignore this cycle's line
- line_valid  in  1  line_data/offset/line_pc valid
- line_ready  out  1  queue can accept a full line
- line_data  in  LINE_WORDS*32  cache line; word i at bits [32i+31:32i]
- offset  in  log2(LINE_WORDS)  index of the first wanted word
- line_pc  in  PC_W  PC of word[offset]
- out_valid  out  FETCH_WIDTH  per-lane valid; always contiguous from lane 0
- out_inst  out  FETCH_WIDTH*32  lane k instruction at [32k+31:32k]
- out_pc  out  FETCH_WIDTH*PC_W  lane k PC
- out_ready  in  1  decode consumes every valid lane this cycle

## Operation
- Push: when line_valid && line_ready && !flush, enqueue words offset..LINE_WORDS-1 in ascending order.
  - Push count n = LINE_WORDS - offset, range 1..LINE_WORDS.
  - Entry j gets PC line_pc + 4j; PC arithmetic wraps modulo 2^PC_W.
- line_ready = (DEPTH - count) ≥ LINE_WORDS. It is a function of registered count only; no path from out_ready or flush.
- Pop: lane k is valid iff k < count. Lanes show the head entries in order. When out_ready, count_pop = min(count, FETCH_WIDTH) entries are retired.
- Invalid lanes drive inst 32'h0 and pc 0.
- Storage: circular buffer. head/tail pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
  - Next count = count + push_n − pop_n.
- Simultaneous push and pop in one cycle is legal. Both apply. The pop uses the pre-push contents.
- Flush has priority. On the next edge head = tail = count = 0. Any push and pop in the flush cycle have no effect.
- Reset (asynchronous, any time): head, tail and count go to 0. Storage is not reset.
- Reset values of outputs: out_valid = 0, out_inst = 0, out_pc = 0, line_ready = 1.
- Write-enable discipline:
  - Storage is written only on an accepted push.
  - A line_valid while line_ready = 0 is ignored. The cache holds it.

## Timing
- Latency: a line accepted at edge N is visible on the out_* lanes in cycle N+1. There is no same-cycle bypass.
- out_* are combinational from the registered head, count and storage. There is no combinational path from line_* to out_*.
- Throughput: sustained FETCH_WIDTH instructions per cycle when lines arrive continuously and decode never stalls.
- Full boundary: with count = DEPTH − LINE_WORDS + 1, line_ready = 0 even if that cycle pops.
- Empty boundary: with count = 0, all out_valid = 0, and out_ready has no effect.

## Structure
- Shared package fetch_pkg holds:
  - INST_W = 32
  - the LoongArch NOP constant 32'h0340_0000, for decode-side use
  - the function clog2_min1
- One natural sub-module: fetch_line_extract. It is combinational; it maps line_data and offset to a word vector shifted down by offset and the push count n.
- The queue pointers and counters live in fetch_align_queue.

## Test plan
- Reset then one line with line_pc 0x1c000000, offset 0, data 0x11/0x22/0x33/0x44:
  - next cycle: out_valid 2'b11, inst 0x11/0x22, pc 0x1c000000/0x1c000004
  - with out_ready=1: then 0x33/0x44
  - after that: out_valid 0
- offset 3, line_pc 0x1c00001c: exactly one entry. out_valid 2'b01, lane1 inst 0 and pc 0.
- Fill check with DEPTH 8:
  - Push two lines with offset 0 while out_ready=0 → count 8, line_ready=0.
  - A third line_valid is held. Queue contents are unchanged.
  - One pop cycle → count 6, line_ready still 0.
  - Second pop → count 4, line_ready=1.
- Simultaneous push (offset 2) and pop at count 3 → count 3 − 2 + 2 = 3 next cycle. Order preserved across pointer wrap from entry 7 to entry 0.
- flush asserted together with line_valid and out_ready at count 5 → count 0 next cycle, out_valid 0, no entry enqueued.
- rstn pulsed low mid-stream at count 6 → out_valid 0 and line_ready 1 immediately, asynchronously. Normal operation resumes after release.
